mips_controller: RTL and testbench
==================================

# mips_controller

Combinational main decoder for the single-cycle MIPS datapath. It maps the instruction `Opcode` and `Funct` fields to every datapath control signal: PC select, register-file write, ALU operand and operation, data-memory write, and immediate extension. It also flags unsupported encodings and can keep a sticky illegal-instruction status register, which is the block's only clocked logic. It sits between the instruction memory and the datapath.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; used only by the sticky status register.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Opcode` in 6: instr[31:26].
- `Funct` in 6: instr[5:0].
- `IsBr` out 1: conditional branch (beq).
- `Jump` out 1: unconditional PC redirect (j, jal, jr).
- `JType` out 1: jump target source. 0 = imm26 (j/jal); 1 = register rs (jr).
- `RegA3Sel` out 1: write-register select. 0 = rt; 1 = rd.
- `SaveRA` out 1: force the write register to $31 (jal).
- `DatatoReg` out 2: write-data source. 00 = ALU; 01 = DM; 10 = PC+4; 11 = reserved.
- `RegWE` out 1: register-file write enable.
- `ALUBSel` out 1: ALU B operand. 0 = rt; 1 = extended immediate.
- `DMWE` out 1: data-memory write enable.
- `EXTCtrl` out 2: immediate extension. 00 = zero-extend; 01 = sign-extend; 10 = imm<<16; 11 = reserved.
- `ALUCtrl` out 8: one-hot ALU operation. ADD = 8'h01, SUB = 8'h02, OR = 8'h04, PASSB = 8'h08. All other codes are reserved.
- `Illegal` out 1: combinational; current encoding is unsupported.
- `IllegalSticky` out 1: registered; set by any illegal encoding.

## Operation
Decode table. Any signal not listed is 0, and ALUCtrl defaults to ADD.
- addu (op 000000, funct 100001): RegWE, RegA3Sel = 1, ALU ADD.
- subu (op 000000, funct 100011): RegWE, RegA3Sel = 1, ALU SUB.
- jr (op 000000, funct 001000): Jump, JType = 1.
- nop (op 000000, funct 000000): all zero, legal.
- ori (001101): RegWE, ALUBSel, EXTCtrl = 00, ALU OR.
- lw (100011): RegWE, ALUBSel, EXTCtrl = 01, DatatoReg = 01, ALU ADD.
- sw (101011): DMWE, ALUBSel, EXTCtrl = 01, ALU ADD.
- beq (000100): IsBr, EXTCtrl = 01, ALU SUB.
- lui (001111): RegWE, ALUBSel, EXTCtrl = 10, ALU PASSB.
- j (000010): Jump, JType = 0.
- jal (000011): Jump, JType = 0, RegWE, SaveRA, DatatoReg = 10.

Illegal encodings:
- Any other opcode, or opcode 000000 with any other funct, is illegal.
- Every control output is then 0 (ALUCtrl = ADD), so the instruction has no side effects.
- `Illegal` = 1.

## Timing
- All control outputs and `Illegal` are purely combinational: zero-cycle latency, no internal state.
- `IllegalSticky` is cleared asynchronously while `rst_n` = 0 and reads 0 out of reset.
- On each rising `clk` edge with `rst_n` = 1, `IllegalSticky` <= `IllegalSticky` | `Illegal`.
- It stays 1 until reset.
- Reset asserted mid-operation clears the flag immediately. Decode outputs are unaffected by reset.

## Configuration
- `CTRL_ILLEGAL_STICKY_EN` defined: the sticky register exists as described above.
- Not defined: `IllegalSticky` is tied to 0, no flop is instantiated, and `clk`/`rst_n` are accepted but unused.
- `Illegal` and all decode behaviour are identical in both builds.

## Structure
- A shared package `mips_pkg` holds:
  - opcode and funct localparams;
  - ALUCtrl one-hot codes;
  - EXTCtrl and DatatoReg encodings.
- One sub-module, `mips_alu_dec`, maps the (Opcode, Funct) class to `ALUCtrl`. The main decode and the sticky flop stay in `mips_controller`.

## Test plan
- Opcode = 001101 (ori), Funct = 0 -> RegWE = 1, ALUBSel = 1, EXTCtrl = 00, ALUCtrl = 8'h04; all others 0; Illegal = 0.
- Opcode = 0, Funct = 100011 (subu) -> RegWE = 1, RegA3Sel = 1, ALUCtrl = 8'h02; Opcode = 0, Funct = 0 -> all outputs 0, ALUCtrl = 8'h01.
- Opcode = 000011 (jal) -> Jump = 1, JType = 0, SaveRA = 1, RegWE = 1, DatatoReg = 10; Opcode = 0, Funct = 001000 (jr) -> Jump = 1, JType = 1, RegWE = 0.
- lw/sw/beq/lui each -> table values, e.g. lw DatatoReg = 01, EXTCtrl = 01; sw DMWE = 1, RegWE = 0; lui EXTCtrl = 10, ALUCtrl = 8'h08.
- Opcode = 111111 -> Illegal = 1, RegWE = DMWE = Jump = IsBr = 0. After the next clk edge, IllegalSticky = 1, and it stays 1 after returning to a legal op.
- Pulse `rst_n` low asynchronously with no clk edge -> IllegalSticky = 0 immediately. With the macro undefined -> IllegalSticky = 0 always.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the single-cycle MIPS control path.
// Holds opcode/funct values, the one-hot ALUCtrl codes, the EXTCtrl and
// DatatoReg encodings, and the packed decode record used by
// mips_controller.
package mips_pkg;

  // Opcode field, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field, instr[5:0], meaningful only for OP_RTYPE
  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  // One-hot ALU operations
  localparam logic [7:0] ALU_ADD   = 8'h01;
  localparam logic [7:0] ALU_SUB   = 8'h02;
  localparam logic [7:0] ALU_OR    = 8'h04;
  localparam logic [7:0] ALU_PASSB = 8'h08;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Register write-data source
  localparam logic [1:0] D2R_ALU = 2'b00;
  localparam logic [1:0] D2R_DM  = 2'b01;
  localparam logic [1:0] D2R_PC4 = 2'b10;

  // Non-ALU decode outputs, grouped so the decoder can clear them in one go.
  typedef struct packed {
    logic       is_br;
    logic       jump;
    logic       jtype;
    logic       reg_a3_sel;
    logic       save_ra;
    logic [1:0] data_to_reg;
    logic       reg_we;
    logic       alub_sel;
    logic       dm_we;
    logic [1:0] ext_ctrl;
    logic       illegal;
  } ctrl_t;

  // True for every encoding the datapath implements.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADDU) || (fn == FN_SUBU) ||
                     (fn == FN_JR)   || (fn == FN_NOP);
      OP_J, OP_JAL, OP_BEQ, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: ALU operation decoder.
// Ports:
//   Opcode  in  6  instr[31:26]
//   Funct   in  6  instr[5:0]
//   ALUCtrl out 8  one-hot ALU operation; ADD for everything not listed,
//                  including illegal encodings.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic [7:0] ALUCtrl
);

  always_comb begin
    ALUCtrl = ALU_ADD;
    case (Opcode)
      OP_RTYPE: if (Funct == FN_SUBU) ALUCtrl = ALU_SUB;
      OP_ORI:   ALUCtrl = ALU_OR;
      OP_BEQ:   ALUCtrl = ALU_SUB;
      OP_LUI:   ALUCtrl = ALU_PASSB;
      default:  ALUCtrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// mips_controller: combinational main decoder for the single-cycle MIPS
// datapath, plus an optional sticky illegal-instruction flag.
// Build option: CTRL_ILLEGAL_STICKY_EN -- when defined, IllegalSticky is a
// flop (async active-low reset) that accumulates Illegal; otherwise it is
// tied low and clk/rst_n are unused.
// Ports:
//   clk, rst_n        clock and async active-low reset (sticky flag only)
//   Opcode, Funct     instruction fields
//   IsBr, Jump, JType branch/jump controls
//   RegA3Sel, SaveRA  write-register select / force $31
//   DatatoReg         write-data source (00 ALU, 01 DM, 10 PC+4)
//   RegWE, ALUBSel    register write enable, ALU B = immediate
//   DMWE              data-memory write enable
//   EXTCtrl           immediate extension (00 zero, 01 sign, 10 <<16)
//   ALUCtrl           one-hot ALU operation
//   Illegal           current encoding unsupported (combinational)
//   IllegalSticky     registered OR of Illegal since reset
module mips_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic       IsBr,
  output logic       Jump,
  output logic       JType,
  output logic       RegA3Sel,
  output logic       SaveRA,
  output logic [1:0] DatatoReg,
  output logic       RegWE,
  output logic       ALUBSel,
  output logic       DMWE,
  output logic [1:0] EXTCtrl,
  output logic [7:0] ALUCtrl,
  output logic       Illegal,
  output logic       IllegalSticky
);

  ctrl_t ctrl;

  mips_alu_dec u_alu_dec (
    .Opcode  (Opcode),
    .Funct   (Funct),
    .ALUCtrl (ALUCtrl)
  );

  always_comb begin
    ctrl         = '0;
    ctrl.illegal = !is_legal(Opcode, Funct);
    case (Opcode)
      OP_RTYPE: begin
        case (Funct)
          FN_ADDU, FN_SUBU: begin
            ctrl.reg_we     = 1'b1;
            ctrl.reg_a3_sel = 1'b1;
          end
          FN_JR: begin
            ctrl.jump  = 1'b1;
            ctrl.jtype = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        ctrl.reg_we   = 1'b1;
        ctrl.alub_sel = 1'b1;
        ctrl.ext_ctrl = EXT_ZERO;
      end
      OP_LW: begin
        ctrl.reg_we      = 1'b1;
        ctrl.alub_sel    = 1'b1;
        ctrl.ext_ctrl    = EXT_SIGN;
        ctrl.data_to_reg = D2R_DM;
      end
      OP_SW: begin
        ctrl.dm_we    = 1'b1;
        ctrl.alub_sel = 1'b1;
        ctrl.ext_ctrl = EXT_SIGN;
      end
      OP_BEQ: begin
        ctrl.is_br    = 1'b1;
        ctrl.ext_ctrl = EXT_SIGN;
      end
      OP_LUI: begin
        ctrl.reg_we   = 1'b1;
        ctrl.alub_sel = 1'b1;
        ctrl.ext_ctrl = EXT_LUI;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump        = 1'b1;
        ctrl.reg_we      = 1'b1;
        ctrl.save_ra     = 1'b1;
        ctrl.data_to_reg = D2R_PC4;
      end
      default: ;
    endcase
  end

  assign IsBr      = ctrl.is_br;
  assign Jump      = ctrl.jump;
  assign JType     = ctrl.jtype;
  assign RegA3Sel  = ctrl.reg_a3_sel;
  assign SaveRA    = ctrl.save_ra;
  assign DatatoReg = ctrl.data_to_reg;
  assign RegWE     = ctrl.reg_we;
  assign ALUBSel   = ctrl.alub_sel;
  assign DMWE      = ctrl.dm_we;
  assign EXTCtrl   = ctrl.ext_ctrl;
  assign Illegal   = ctrl.illegal;

`ifdef CTRL_ILLEGAL_STICKY_EN
  logic sticky_q;
  logic sticky_d;

  assign sticky_d = sticky_q | ctrl.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign IllegalSticky = sticky_q;
`else
  // Clock and reset have no load in this build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign IllegalSticky  = 1'b0;
`endif

endmodule

// File: tb/tb_mips_controller.sv
module tb_mips_controller;

`ifdef CTRL_ILLEGAL_STICKY_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       IsBr, Jump, JType, RegA3Sel, SaveRA, RegWE, ALUBSel, DMWE;
  logic [1:0] DatatoReg, EXTCtrl;
  logic [7:0] ALUCtrl;
  logic       Illegal, IllegalSticky;

  int n_cmp = 0;
  int n_err = 0;

  mips_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Opcode        (Opcode),
    .Funct         (Funct),
    .IsBr          (IsBr),
    .Jump          (Jump),
    .JType         (JType),
    .RegA3Sel      (RegA3Sel),
    .SaveRA        (SaveRA),
    .DatatoReg     (DatatoReg),
    .RegWE         (RegWE),
    .ALUBSel       (ALUBSel),
    .DMWE          (DMWE),
    .EXTCtrl       (EXTCtrl),
    .ALUCtrl       (ALUCtrl),
    .Illegal       (Illegal),
    .IllegalSticky (IllegalSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: {IsBr,Jump,JType,RegA3Sel,SaveRA,DatatoReg,RegWE,ALUBSel,
  //               DMWE,EXTCtrl,ALUCtrl,Illegal} = 21 bits
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [20:0] exp;
  } vec_t;

  function automatic logic [20:0] ew(
    input logic br, input logic jp, input logic jt, input logic a3,
    input logic ra, input logic [1:0] d2r, input logic we, input logic bs,
    input logic dm, input logic [1:0] ext, input logic [7:0] alu,
    input logic ill);
    return {br, jp, jt, a3, ra, d2r, we, bs, dm, ext, alu, ill};
  endfunction

  function automatic logic [20:0] actual();
    return {IsBr, Jump, JType, RegA3Sel, SaveRA, DatatoReg, RegWE, ALUBSel,
            DMWE, EXTCtrl, ALUCtrl, Illegal};
  endfunction

  task automatic check(input string name, input logic [20:0] act,
                       input logic [20:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t tbl[17];

  initial begin
    //                     br jp jt a3 ra d2r    we bs dm ext    alu    ill
    tbl[0]  = '{"addu",  6'h00, 6'h21, ew(0,0,0,1,0,2'b00,1,0,0,2'b00,8'h01,0)};
    tbl[1]  = '{"subu",  6'h00, 6'h23, ew(0,0,0,1,0,2'b00,1,0,0,2'b00,8'h02,0)};
    tbl[2]  = '{"jr",    6'h00, 6'h08, ew(0,1,1,0,0,2'b00,0,0,0,2'b00,8'h01,0)};
    tbl[3]  = '{"nop",   6'h00, 6'h00, ew(0,0,0,0,0,2'b00,0,0,0,2'b00,8'h01,0)};
    tbl[4]  = '{"ori",   6'h0d, 6'h00, ew(0,0,0,0,0,2'b00,1,1,0,2'b00,8'h04,0)};
    tbl[5]  = '{"lw",    6'h23, 6'h00, ew(0,0,0,0,0,2'b01,1,1,0,2'b01,8'h01,0)};
    tbl[6]  = '{"sw",    6'h2b, 6'h00, ew(0,0,0,0,0,2'b00,0,1,1,2'b01,8'h01,0)};
    tbl[7]  = '{"beq",   6'h04, 6'h00, ew(1,0,0,0,0,2'b00,0,0,0,2'b01,8'h02,0)};
    tbl[8]  = '{"lui",   6'h0f, 6'h00, ew(0,0,0,0,0,2'b00,1,1,0,2'b10,8'h08,0)};
    tbl[9]  = '{"j",     6'h02, 6'h00, ew(0,1,0,0,0,2'b00,0,0,0,2'b00,8'h01,0)};
    tbl[10] = '{"jal",   6'h03, 6'h00, ew(0,1,0,0,1,2'b10,1,0,0,2'b00,8'h01,0)};
    tbl[11] = '{"op3f",  6'h3f, 6'h00, ew(0,0,0,0,0,2'b00,0,0,0,2'b00,8'h01,1)};
    tbl[12] = '{"add20", 6'h00, 6'h20, ew(0,0,0,0,0,2'b00,0,0,0,2'b00,8'h01,1)};
    tbl[13] = '{"sub22", 6'h00, 6'h22, ew(0,0,0,0,0,2'b00,0,0,0,2'b00,8'h01,1)};
    tbl[14] = '{"ori_f", 6'h0d, 6'h3f, ew(0,0,0,0,0,2'b00,1,1,0,2'b00,8'h04,0)};
    tbl[15] = '{"op3f_f",6'h3f, 6'h23, ew(0,0,0,0,0,2'b00,0,0,0,2'b00,8'h01,1)};
    tbl[16] = '{"op01",  6'h01, 6'h21, ew(0,0,0,0,0,2'b00,0,0,0,2'b00,8'h01,1)};

    rst_n  = 1'b0;
    Opcode = 6'h0d;
    Funct  = 6'h00;
    #1;
    // Decode must work while reset is held.
    check("ori_in_reset", actual(), tbl[4].exp);
    check("sticky_reset", {20'd0, IllegalSticky}, 21'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational table; inputs change away from the rising edge and any
    // illegal entries are covered by the sticky sequence below.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      Opcode = tbl[i].op;
      Funct  = tbl[i].fn;
      #1;
      check(tbl[i].name, actual(), tbl[i].exp);
    end

    // Sticky flag: clear it, then walk legal -> illegal -> legal.
    @(negedge clk);
    Opcode = 6'h00; Funct = 6'h21;
    rst_n  = 1'b0;
    #1;
    rst_n  = 1'b1;
    @(posedge clk); #1;
    check("sticky_legal", {20'd0, IllegalSticky}, 21'd0);

    @(negedge clk);
    Opcode = 6'h3f; Funct = 6'h00;
    #1;
    check("illegal_now", actual(), tbl[11].exp);
    check("sticky_before_edge", {20'd0, IllegalSticky}, 21'd0);
    @(posedge clk); #1;
    check("sticky_set", {20'd0, IllegalSticky}, {20'd0, STICKY_EN});

    @(negedge clk);
    Opcode = 6'h23; Funct = 6'h00;
    @(posedge clk); #1;
    check("lw_after_illegal", actual(), tbl[5].exp);
    check("sticky_hold", {20'd0, IllegalSticky}, {20'd0, STICKY_EN});
    @(posedge clk); #1;
    check("sticky_hold2", {20'd0, IllegalSticky}, {20'd0, STICKY_EN});

    // Async clear between edges.
    #1 rst_n = 1'b0;
    #1;
    check("sticky_async_clr", {20'd0, IllegalSticky}, 21'd0);
    check("lw_in_reset", actual(), tbl[5].exp);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("sticky_after_clr", {20'd0, IllegalSticky}, 21'd0);

    // Illegal presented while reset is held must not set the flag.
    @(negedge clk);
    rst_n  = 1'b0;
    Opcode = 6'h00; Funct = 6'h3f;
    @(posedge clk); #1;
    check("sticky_in_reset", {20'd0, IllegalSticky}, 21'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("sticky_rfn_illegal", {20'd0, IllegalSticky}, {20'd0, STICKY_EN});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
